// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and the burst-master FSM state type.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R
    } axi4_mst_state_e;

endpackage

// File: rtl/axi4_burst_master.sv
// AXI4 initiator: one command becomes one INCR burst, one transaction in flight.
// Write data streams in and read data streams out with zero added beat latency.
module axi4_burst_master
    import axi4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MST_ID     = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [7:0]              cmd_len_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_last_o,
    output logic                    done_o,
    output logic [1:0]              resp_o,
    output logic [ID_WIDTH-1:0]     awid_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic [7:0]              awlen_o,
    output logic [2:0]              awsize_o,
    output logic [1:0]              awburst_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wlast_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [ID_WIDTH-1:0]     bid_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    output logic [ID_WIDTH-1:0]     arid_o,
    output logic [ADDR_WIDTH-1:0]   araddr_o,
    output logic [7:0]              arlen_o,
    output logic [2:0]              arsize_o,
    output logic [1:0]              arburst_o,
    output logic                    arvalid_o,
    input  logic                    arready_i,
    input  logic [ID_WIDTH-1:0]     rid_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic [1:0]              rresp_i,
    input  logic                    rlast_i,
    input  logic                    rvalid_i,
    output logic                    rready_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SIZE       = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    axi4_mst_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  done_q, done_d;
    logic [1:0]            resp_q, resp_d;
    logic                  w_hs, r_hs, cnt_at_len;
    logic                  unused_ids;

    // Last byte of the burst, computed in 14 bits, must stay inside the 4 KB page.
    function automatic logic crosses_4k(input logic [11:0] addr, input logic [7:0] len);
        logic [13:0] last_byte;
        last_byte = 14'(addr) + ((14'(len) + 14'd1) << SIZE) - 14'd1;
        return last_byte > 14'hFFF;
    endfunction

    assign unused_ids = ^{bid_i, rid_i};

    assign cnt_at_len = (cnt_q == len_q);
    assign w_hs       = (state_q == ST_W) && wr_valid_i && wready_i;
    assign r_hs       = (state_q == ST_R) && rvalid_i && rd_ready_i;

    assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign done_o      = done_q;
    assign resp_o      = resp_q;

    assign awid_o    = ID_WIDTH'(MST_ID);
    assign awaddr_o  = addr_q;
    assign awlen_o   = len_q;
    assign awsize_o  = 3'(SIZE);
    assign awburst_o = BURST_INCR;
    assign awvalid_o = awvalid_q;

    assign arid_o    = ID_WIDTH'(MST_ID);
    assign araddr_o  = addr_q;
    assign arlen_o   = len_q;
    assign arsize_o  = 3'(SIZE);
    assign arburst_o = BURST_INCR;
    assign arvalid_o = arvalid_q;

    assign wvalid_o   = (state_q == ST_W) && wr_valid_i;
    assign wr_ready_o = (state_q == ST_W) && wready_i;
    assign wdata_o    = wr_data_i;
    assign wstrb_o    = wr_strb_i;
    assign wlast_o    = (state_q == ST_W) && cnt_at_len;

    assign bready_o = (state_q == ST_B);

    assign rd_valid_o = (state_q == ST_R) && rvalid_i;
    assign rready_o   = (state_q == ST_R) && rd_ready_i;
    assign rd_data_o  = rdata_i;
    assign rd_last_o  = rlast_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            awvalid_q <= awvalid_d;
            arvalid_q <= arvalid_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        awvalid_d = awvalid_q;
        arvalid_d = arvalid_q;
        done_d    = 1'b0;
        resp_d    = resp_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d = cmd_addr_i & ALIGN_MASK;
                    len_d  = cmd_len_i;
                    cnt_d  = '0;
                    if (crosses_4k(cmd_addr_i[11:0], cmd_len_i)) begin
                        resp_d = RESP_SLVERR;
                        done_d = 1'b1;
                    end else begin
                        resp_d = RESP_OKAY;
                        if (cmd_write_i) begin
                            awvalid_d = 1'b1;
                            state_d   = ST_AW;
                        end else begin
                            arvalid_d = 1'b1;
                            state_d   = ST_AR;
                        end
                    end
                end
            end
            ST_AW: begin
                if (awready_i) begin
                    awvalid_d = 1'b0;
                    state_d   = ST_W;
                end
            end
            ST_W: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_at_len) state_d = ST_B;
                end
            end
            ST_B: begin
                if (bvalid_i) begin
                    resp_d  = bresp_i;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_AR: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                // First error response is sticky; a misplaced rlast overrides it.
                if (r_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (resp_q == RESP_OKAY && rresp_i != RESP_OKAY) resp_d = rresp_i;
                    if (rlast_i != cnt_at_len) resp_d = RESP_SLVERR;
                    if (rlast_i) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master against a small behavioural 512x32 AXI slave.
module tb_axi4_burst_master;
    import axi4_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [7:0]  cmd_len_i;
    logic        wr_valid_i, wr_ready_o;
    logic [31:0] wr_data_i;
    logic [3:0]  wr_strb_i;
    logic        rd_valid_o, rd_ready_i, rd_last_o;
    logic [31:0] rd_data_o;
    logic        done_o;
    logic [1:0]  resp_o;
    logic [3:0]  awid_o, arid_o, bid_i, rid_i;
    logic [31:0] awaddr_o, araddr_o, wdata_o, rdata_i;
    logic [7:0]  awlen_o, arlen_o;
    logic [2:0]  awsize_o, arsize_o;
    logic [1:0]  awburst_o, arburst_o, bresp_i, rresp_i;
    logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
    logic        bvalid_i, bready_o, arvalid_o, arready_i;
    logic        rlast_i, rvalid_i, rready_o;
    logic [3:0]  wstrb_o;

    always #5 clk_i = ~clk_i;

    axi4_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MST_ID(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
        .done_o(done_o), .resp_o(resp_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
        .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    // Behavioural slave: counts its own beats from awlen/arlen, resets with the master.
    logic [31:0] mem [0:511];
    logic        s_wact, s_ract, wready_en;
    logic [8:0]  s_wptr, s_rptr;
    logic [7:0]  s_wcnt, s_wlen, s_rcnt, s_rlen;

    assign awready_i = !s_wact && !bvalid_i;
    assign wready_i  = s_wact && wready_en;
    assign arready_i = !s_ract;
    assign rvalid_i  = s_ract;
    assign rdata_i   = mem[s_rptr];
    assign rlast_i   = s_ract && (s_rcnt == s_rlen);
    assign bresp_i   = RESP_OKAY;
    assign rresp_i   = RESP_OKAY;
    assign bid_i     = 4'd3;
    assign rid_i     = 4'd3;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_wact <= 1'b0; s_ract <= 1'b0; bvalid_i <= 1'b0;
            s_wptr <= '0; s_rptr <= '0; s_wcnt <= '0; s_wlen <= '0; s_rcnt <= '0; s_rlen <= '0;
            for (int i = 0; i < 512; i++) mem[i] <= 32'hA5A5A5A5;
        end else begin
            if (awvalid_o && awready_i) begin
                s_wact <= 1'b1; s_wptr <= awaddr_o[10:2]; s_wcnt <= '0; s_wlen <= awlen_o;
            end
            if (wvalid_o && wready_i) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb_o[b]) mem[s_wptr][8*b +: 8] <= wdata_o[8*b +: 8];
                s_wptr <= s_wptr + 9'd1;
                s_wcnt <= s_wcnt + 8'd1;
                if (s_wcnt == s_wlen) begin
                    s_wact   <= 1'b0;
                    bvalid_i <= 1'b1;
                end
            end
            if (bvalid_i && bready_o) bvalid_i <= 1'b0;
            if (arvalid_o && arready_i) begin
                s_ract <= 1'b1; s_rptr <= araddr_o[10:2]; s_rcnt <= '0; s_rlen <= arlen_o;
            end
            if (rvalid_i && rready_o) begin
                s_rptr <= s_rptr + 9'd1;
                s_rcnt <= s_rcnt + 8'd1;
                if (rlast_i) s_ract <= 1'b0;
            end
        end
    end

    // Transfer logs filled on each handshake.
    int          aw_total = 0, ar_total = 0, w_total = 0, r_total = 0;
    logic        w_last_log [0:255];
    logic        r_last_log [0:255];
    logic [31:0] r_data_log [0:255];
    logic [31:0] aw_addr_seen, ar_addr_seen;
    logic [7:0]  aw_len_seen;
    logic [2:0]  aw_size_seen;
    logic [1:0]  aw_burst_seen;
    logic [3:0]  aw_id_seen;

    always @(posedge clk_i) begin
        if (awvalid_o && awready_i) begin
            aw_total      <= aw_total + 1;
            aw_addr_seen  <= awaddr_o;
            aw_len_seen   <= awlen_o;
            aw_size_seen  <= awsize_o;
            aw_burst_seen <= awburst_o;
            aw_id_seen    <= awid_o;
        end
        if (arvalid_o && arready_i) begin
            ar_total     <= ar_total + 1;
            ar_addr_seen <= araddr_o;
        end
        if (wvalid_o && wready_i) begin
            w_last_log[w_total % 256] <= wlast_o;
            w_total <= w_total + 1;
        end
        if (rd_valid_o && rd_ready_i) begin
            r_data_log[r_total % 256] <= rd_data_o;
            r_last_log[r_total % 256] <= rd_last_o;
            r_total <= r_total + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
        bit got;
        got = 1'b0;
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_len_i = len;
        for (int t = 0; t < 100 && !got; t++) begin
            #1;
            got = cmd_ready_o;
            @(posedge clk_i);
            if (!got) @(negedge clk_i);
        end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("cmd_accept", 64'(got), 64'd1);
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [3:0] s, input int gap, input bit rnd);
        bit got;
        got = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk_i);
            wr_valid_i = 1'b0;
            if (rnd) wready_en = 1'($urandom_range(0, 1));
            @(posedge clk_i);
        end
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk_i);
            wr_valid_i = 1'b1; wr_data_i = d; wr_strb_i = s;
            if (rnd) wready_en = 1'($urandom_range(0, 1));
            #1;
            got = wr_ready_o;
            @(posedge clk_i);
        end
        chk("wr_beat_accept", 64'(got), 64'd1);
    endtask

    task automatic wait_done(input bit rnd_rd);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 1000 && !got; t++) begin
            @(negedge clk_i);
            wr_valid_i = 1'b0;
            wready_en  = 1'b1;
            rd_ready_i = rnd_rd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            got = done_o;
        end
        chk("done_seen", 64'(got), 64'd1);
    endtask

    initial begin
        int  w0, r0, a0, ar0, n;
        bit  got;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
        wr_valid_i = 1'b0; wr_data_i = '0; wr_strb_i = '0; rd_ready_i = 1'b0; wready_en = 1'b1;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        chk("rst_valids", 64'({awvalid_o, arvalid_o, wvalid_o, bready_o, rready_o, rd_valid_o}), 64'd0);
        chk("rst_done_resp", 64'({done_o, resp_o}), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);

        // Write 4 beats at 0x100
        w0 = w_total; a0 = aw_total;
        send_cmd(1'b1, 32'h100, 8'd3);
        chk("aw_latency", 64'(awvalid_o), 64'd1);
        for (int i = 0; i < 4; i++) push_beat(32'(8'h11 * (i + 1)), 4'hF, 0, 1'b0);
        wait_done(1'b0);
        chk("wr4_resp", 64'(resp_o), 64'd0);
        chk("wr4_aw_count", 64'(aw_total - a0), 64'd1);
        chk("wr4_awaddr", 64'(aw_addr_seen), 64'h100);
        chk("wr4_awlen_size_burst_id", 64'({aw_len_seen, aw_size_seen, aw_burst_seen, aw_id_seen}),
            64'({8'd3, 3'd2, 2'b01, 4'd3}));
        chk("wr4_beats", 64'(w_total - w0), 64'd4);
        chk("wr4_wlast_pos", 64'({w_last_log[w0], w_last_log[w0+1], w_last_log[w0+2], w_last_log[w0+3]}), 64'b0001);
        for (int i = 0; i < 4; i++) chk("wr4_mem", 64'(mem[64 + i]), 64'(8'h11 * (i + 1)));
        @(negedge clk_i);
        chk("done_one_cycle", 64'(done_o), 64'd0);

        // Read back 4 beats at 0x100
        r0 = r_total;
        send_cmd(1'b0, 32'h100, 8'd3);
        chk("ar_latency", 64'(arvalid_o), 64'd1);
        wait_done(1'b0);
        chk("rd4_resp", 64'(resp_o), 64'd0);
        chk("rd4_beats", 64'(r_total - r0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rd4_data", 64'(r_data_log[r0 + i]), 64'(8'h11 * (i + 1)));
            chk("rd4_last", 64'(r_last_log[r0 + i]), 64'(i == 3));
        end

        // 16-beat write and read with random gaps on both sides
        w0 = w_total;
        send_cmd(1'b1, 32'h200, 8'd15);
        for (int i = 0; i < 16; i++) push_beat(32'hC0DE0000 + 32'(i), 4'hF, int'($urandom_range(0, 2)), 1'b1);
        wait_done(1'b0);
        chk("bp_wr_resp", 64'(resp_o), 64'd0);
        chk("bp_wr_beats", 64'(w_total - w0), 64'd16);
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(w_last_log[w0 + i]);
        chk("bp_wlast_count", 64'(n), 64'd1);
        chk("bp_wlast_pos", 64'(w_last_log[w0 + 15]), 64'd1);
        n = 0;
        for (int i = 0; i < 16; i++) if (mem[128 + i] !== 32'hC0DE0000 + 32'(i)) n++;
        chk("bp_mem_errors", 64'(n), 64'd0);
        r0 = r_total;
        send_cmd(1'b0, 32'h200, 8'd15);
        wait_done(1'b1);
        chk("bp_rd_resp", 64'(resp_o), 64'd0);
        chk("bp_rd_beats", 64'(r_total - r0), 64'd16);
        for (int i = 0; i < 16; i++) chk("bp_rd_data", 64'(r_data_log[r0 + i]), 64'(32'hC0DE0000 + 32'(i)));
        chk("bp_rd_last", 64'(r_last_log[r0 + 15]), 64'd1);

        // 4 KB boundary: 0xFF8 + 16 bytes crosses, 0xFF0 + 16 bytes ends exactly at 0xFFF
        a0 = aw_total; ar0 = ar_total; w0 = w_total;
        send_cmd(1'b1, 32'hFF8, 8'd3);
        chk("bnd_done", 64'(done_o), 64'd1);
        chk("bnd_resp", 64'(resp_o), 64'(RESP_SLVERR));
        chk("bnd_no_aw", 64'({awvalid_o, cmd_ready_o}), 64'b01);
        @(negedge clk_i);
        chk("bnd_done_drop_resp_hold", 64'({done_o, resp_o}), 64'({1'b0, RESP_SLVERR}));
        chk("bnd_no_traffic", 64'({aw_total - a0, w_total - w0}), 64'd0);
        r0 = r_total;
        send_cmd(1'b0, 32'hFF0, 8'd3);
        wait_done(1'b0);
        chk("bnd_edge_resp", 64'(resp_o), 64'd0);
        chk("bnd_edge_beats", 64'({ar_total - ar0, r_total - r0}), 64'({32'd1, 32'd4}));

        // Single beat with partial strobe, then a back-to-back write accepted in the done cycle
        w0 = w_total;
        send_cmd(1'b1, 32'h7FC, 8'd0);
        push_beat(32'h12345678, 4'b0011, 0, 1'b0);
        @(negedge clk_i);
        wr_valid_i = 1'b0;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'h7F8; cmd_len_i = 8'd0;
        #1;
        got = done_o;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk_i);
            #1;
            got = done_o;
        end
        chk("b2b_done_seen", 64'(got), 64'd1);
        chk("b2b_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("single_resp", 64'(resp_o), 64'd0);
        chk("single_wlast", 64'({w_total - w0, 31'd0, w_last_log[w0]}), 64'({32'd1, 32'd1}));
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("b2b_awvalid", 64'({awvalid_o, done_o}), 64'b10);
        push_beat(32'hCAFEF00D, 4'hF, 0, 1'b0);
        wait_done(1'b0);
        chk("b2b_resp", 64'(resp_o), 64'd0);
        r0 = r_total;
        send_cmd(1'b0, 32'h7F8, 8'd1);
        wait_done(1'b0);
        chk("b2b_rd0", 64'(r_data_log[r0]), 64'h00000000CAFEF00D);
        chk("single_rd_strb", 64'(r_data_log[r0 + 1]), 64'h00000000A5A55678);

        // Reset after beat 2 of an 8-beat write
        send_cmd(1'b1, 32'h300, 8'd7);
        push_beat(32'h1, 4'hF, 0, 1'b0);
        push_beat(32'h2, 4'hF, 0, 1'b0);
        @(negedge clk_i);
        wr_valid_i = 1'b1; wr_data_i = 32'h3;
        #1;
        chk("pre_rst_wvalid", 64'(wvalid_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_valids", 64'({awvalid_o, arvalid_o, wvalid_o, bready_o, rready_o, rd_valid_o, wr_ready_o}), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        wr_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        send_cmd(1'b1, 32'h12, 8'd0);
        push_beat(32'h5A5A5A5A, 4'hF, 0, 1'b0);
        wait_done(1'b0);
        chk("post_rst_resp", 64'(resp_o), 64'd0);
        chk("post_rst_awaddr_aligned", 64'(aw_addr_seen), 64'h10);
        r0 = r_total;
        send_cmd(1'b0, 32'h10, 8'd0);
        wait_done(1'b0);
        chk("post_rst_rd", 64'({r_data_log[r0], 31'd0, r_last_log[r0]}), 64'({32'h5A5A5A5A, 32'd1}));
        chk("post_rst_araddr", 64'(ar_addr_seen), 64'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
